ccff_loader: RTL



---
 rtl/ccff_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: streams configuration bytes MSB-first into the fabric's
// configuration chain. It generates the prog_clk shift pulses and collects
// the bits leaving the chain tail into readback bytes.
module ccff_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int DIV       = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       prog_clk,
   output logic       ccff_head,
   input  logic       ccff_tail,
   output logic       busy,
   output logic       done,
   output logic [7:0] rb_data,
   output logic       rb_valid
);

   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BYTE,
      SETUP,
      HIGH,
      DONE
   } state_t;

   state_t state, state_next;

   logic [BW-1:0] bit_cnt;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_in_byte;
   logic [6:0]    data_sr;
   logic [7:0]    rb_sr;
   logic [2:0]    rb_cnt;

   logic handshake;
   logic div_last;
   logic last_bit;

   // byte_ready is high exactly while in WAIT_BYTE, so this is the accept strobe
   assign handshake = byte_valid & byte_ready;
   assign div_last  = (div_cnt == DIV_LAST);
   assign last_bit  = (bit_cnt == LAST_BIT);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one prog_clk period is DIV cycles of SETUP then DIV of HIGH
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_next = WAIT_BYTE;
         end
         WAIT_BYTE: begin
            if (handshake) state_next = SETUP;
         end
         SETUP: begin
            if (div_last) state_next = HIGH;
         end
         HIGH: begin
            if (div_last) begin
               if (last_bit)                 state_next = DONE;
               else if (bit_in_byte == 3'd7) state_next = WAIT_BYTE;
               else                          state_next = SETUP;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Registered outputs, counters, data shifter and readback capture
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_ready  <= 1'b0;
         prog_clk    <= 1'b0;
         ccff_head   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rb_data     <= 8'h00;
         rb_valid    <= 1'b0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         bit_in_byte <= 3'd0;
         data_sr     <= 7'h00;
         rb_sr       <= 8'h00;
         rb_cnt      <= 3'd0;
      end else begin
         byte_ready <= (state_next == WAIT_BYTE);
         prog_clk   <= (state_next == HIGH);
         busy       <= (state_next inside {WAIT_BYTE, SETUP, HIGH});
         done       <= (state_next == DONE);
         rb_valid   <= 1'b0;

         if ((state == SETUP) || (state == HIGH)) begin
            div_cnt <= div_last ? '0 : div_cnt + DW'(1);
         end else begin
            div_cnt <= '0;
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  bit_cnt <= '0;
                  rb_sr   <= 8'h00;
                  rb_cnt  <= 3'd0;
               end
            end
            WAIT_BYTE: begin
               // ccff_head is the top bit; data_sr keeps the seven still to go
               if (handshake) begin
                  ccff_head   <= byte_data[7];
                  data_sr     <= byte_data[6:0];
                  bit_in_byte <= 3'd0;
               end
            end
            SETUP: begin
               // Sample the tail before the upcoming rising edge shifts the chain
               if (div_last) begin
                  rb_sr  <= {rb_sr[6:0], ccff_tail};
                  rb_cnt <= rb_cnt + 3'd1;
                  if (rb_cnt == 3'd7) begin
                     rb_data  <= {rb_sr[6:0], ccff_tail};
                     rb_valid <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (div_last) begin
                  bit_cnt <= bit_cnt + BW'(1);
                  if (last_bit) begin
                     // Flush a partial readback byte, left-aligned
                     if (rb_cnt != 3'd0) begin
                        rb_data  <= rb_sr << (4'd8 - {1'b0, rb_cnt});
                        rb_valid <= 1'b1;
                     end
                  end else if (bit_in_byte != 3'd7) begin
                     ccff_head   <= data_sr[6];
                     data_sr     <= {data_sr[5:0], 1'b0};
                     bit_in_byte <= bit_in_byte + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
